gray_ptr_sync: RTL and testbench

Parametrised multi-stage synchroniser for Gray-coded FIFO pointers, clocked in the destination domain.
Brings an asynchronous Gray pointer through a configurable flop chain, then emits a registered binary equivalent and a one-cycle "pointer moved" pulse.
An optional forward-distance output lets full/empty and almost-full logic consume the synchronised value directly.
Sits between the write/read pointer generators and the opposite-domain status logic of the async FIFO.

---
 rtl/gray_ptr_sync.sv | 119 +++++++++++
 tb/tb_gray_ptr_sync.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
//   Multi-stage synchroniser for a Gray-coded FIFO pointer, clocked in the
//   destination domain. The pointer passes through a plain flop chain, is
//   converted to binary and registered, and a one-cycle pulse marks each
//   change of the registered binary value.
//
// Optional feature macro: GRAY_SYNC_DELTA_EN
//   When defined, adds ptr_delta: the forward distance (mod 2^PTR_W) of the
//   last update, valid in the same cycle as ptr_changed, 0 otherwise.
//
// Ports
//   clk         destination-domain clock
//   rst         asynchronous active-high reset, clears every register
//   sclr        synchronous active-high clear
//   async_grey  Gray pointer from the source domain (asynchronous)
//   sync_grey   synchronised Gray pointer (last chain stage)
//   sync_bin    registered binary form of sync_grey
//   ptr_changed one-cycle pulse when sync_bin takes a new value
//   ptr_delta   forward distance of the last update (GRAY_SYNC_DELTA_EN only)
module gray_ptr_sync #(
    parameter int PTR_W  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic [PTR_W-1:0] async_grey,
    output logic [PTR_W-1:0] sync_grey,
    output logic [PTR_W-1:0] sync_bin,
    output logic             ptr_changed
`ifdef GRAY_SYNC_DELTA_EN
    ,
    output logic [PTR_W-1:0] ptr_delta
`endif
);

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES must be in 2..4");
        end
        if (PTR_W < 2 || PTR_W > 16) begin : g_bad_width
            $error("gray_ptr_sync: PTR_W must be in 2..16");
        end
    endgenerate

    logic [PTR_W-1:0] s_q [STAGES];
    logic [PTR_W-1:0] s_d [STAGES];
    logic [PTR_W-1:0] sync_bin_q, sync_bin_d;
    logic             ptr_changed_q, ptr_changed_d;
    logic [PTR_W-1:0] bin_next;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin_next = '0;
        for (int i = 0; i < PTR_W; i++) begin
            bin_next[i] = ^(s_q[STAGES-1] >> i);
        end
    end

    // Chain has no logic between stages other than the clear mux.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            s_d[i] = '0;
        end
        sync_bin_d    = '0;
        ptr_changed_d = 1'b0;
        if (!sclr) begin
            s_d[0] = async_grey;
            for (int i = 1; i < STAGES; i++) begin
                s_d[i] = s_q[i-1];
            end
            sync_bin_d    = bin_next;
            ptr_changed_d = (bin_next != sync_bin_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                s_q[i] <= '0;
            end
            sync_bin_q    <= '0;
            ptr_changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                s_q[i] <= s_d[i];
            end
            sync_bin_q    <= sync_bin_d;
            ptr_changed_q <= ptr_changed_d;
        end
    end

    assign sync_grey   = s_q[STAGES-1];
    assign sync_bin    = sync_bin_q;
    assign ptr_changed = ptr_changed_q;

`ifdef GRAY_SYNC_DELTA_EN
    logic [PTR_W-1:0] ptr_delta_q, ptr_delta_d;

    // Modular subtraction handles wrap-around with no special case.
    always_comb begin
        ptr_delta_d = '0;
        if (!sclr && (bin_next != sync_bin_q)) begin
            ptr_delta_d = bin_next - sync_bin_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_delta_q <= '0;
        end else begin
            ptr_delta_q <= ptr_delta_d;
        end
    end

    assign ptr_delta = ptr_delta_q;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: a default instance (PTR_W=5, STAGES=2)
// and a STAGES=3 instance for the depth check.
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclr;
    logic [4:0] g;
    logic [4:0] sg, sb;
    logic       pc;
    logic [4:0] g3;
    logic [4:0] sg3, sb3;
    logic       pc3;
`ifdef GRAY_SYNC_DELTA_EN
    logic [4:0] pd, pd3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_ptr_sync #(.PTR_W(5), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .sclr(sclr), .async_grey(g),
        .sync_grey(sg), .sync_bin(sb), .ptr_changed(pc)
`ifdef GRAY_SYNC_DELTA_EN
        , .ptr_delta(pd)
`endif
    );

    gray_ptr_sync #(.PTR_W(5), .STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .sclr(1'b0), .async_grey(g3),
        .sync_grey(sg3), .sync_bin(sb3), .ptr_changed(pc3)
`ifdef GRAY_SYNC_DELTA_EN
        , .ptr_delta(pd3)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Check main outputs; delta only when the feature is built.
    task automatic chk_out(input string tag, input logic [4:0] ebin, input logic epc,
                           input logic [4:0] edelta);
        chk({tag, ".sync_bin"}, 16'(sb), 16'(ebin));
        chk({tag, ".ptr_changed"}, 16'(pc), 16'(epc));
`ifdef GRAY_SYNC_DELTA_EN
        chk({tag, ".ptr_delta"}, 16'(pd), 16'(edelta));
`else
        if (edelta != 5'd0 && !epc) chk({tag, ".delta_arg"}, 16'(edelta), 16'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        sclr = 1'b0;
        g    = 5'b10110;
        g3   = 5'b00000;

        // Reset with nonzero input: everything 0.
        tick(); tick();
        chk("rst.sync_grey", 16'(sg), 16'd0);
        chk_out("rst", 5'd0, 1'b0, 5'd0);

        // Release and capture 10110 -> bin 27.
        rst = 1'b0;
        tick();
        chk("cap1.sync_grey", 16'(sg), 16'd0);
        tick();
        chk("cap2.sync_grey", 16'(sg), 16'b10110);
        chk_out("cap2", 5'd0, 1'b0, 5'd0);
        tick();
        chk_out("cap3", 5'd27, 1'b1, 5'd27);
        tick();
        chk_out("cap4", 5'd27, 1'b0, 5'd0);

        // Return to 0 (delta 5 = 32-27), then increments 1,2,3.
        g = 5'b00000;
        tick(); tick(); tick();
        chk_out("to0", 5'd0, 1'b1, 5'd5);
        tick();
        g = 5'b00001; tick();
        g = 5'b00011; tick();
        g = 5'b00010; tick();
        chk_out("inc1", 5'd1, 1'b1, 5'd1);
        tick();
        chk_out("inc2", 5'd2, 1'b1, 5'd1);
        tick();
        chk_out("inc3", 5'd3, 1'b1, 5'd1);
        tick();
        chk_out("inc_idle", 5'd3, 1'b0, 5'd0);

        // Back to 0, then jump 00110 -> bin 4.
        g = 5'b00000;
        tick(); tick(); tick(); tick();
        chk_out("jmp_pre", 5'd0, 1'b0, 5'd0);
        g = 5'b00110;
        tick(); tick(); tick();
        chk_out("jmp", 5'd4, 1'b1, 5'd4);
        tick();
        chk_out("jmp_idle", 5'd4, 1'b0, 5'd0);

        // 10000 -> bin 31, then wrap to 0 with delta 1.
        g = 5'b10000;
        tick(); tick(); tick();
        chk_out("to31", 5'd31, 1'b1, 5'd27);
        tick();
        g = 5'b00000;
        tick(); tick(); tick();
        chk_out("wrap", 5'd0, 1'b1, 5'd1);
        tick();
        chk_out("wrap_idle", 5'd0, 1'b0, 5'd0);

        // sclr mid-run at sync_bin=27.
        g = 5'b10110;
        tick(); tick(); tick(); tick();
        chk_out("sclr_pre", 5'd27, 1'b0, 5'd0);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("sclr.sync_grey", 16'(sg), 16'd0);
        chk_out("sclr", 5'd0, 1'b0, 5'd0);
        tick(); tick();
        chk_out("sclr_e2", 5'd0, 1'b0, 5'd0);
        tick();
        chk_out("sclr_e3", 5'd27, 1'b1, 5'd27);
        tick();

        // Async reset mid-run while the chain holds a new value.
        g = 5'b00001;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst.sync_grey", 16'(sg), 16'd0);
        chk_out("arst", 5'd0, 1'b0, 5'd0);
        g = 5'b00000;
        tick();
        rst = 1'b0;
        tick();
        chk_out("arst_rel1", 5'd0, 1'b0, 5'd0);
        tick(); tick();
        chk_out("arst_rel3", 5'd0, 1'b0, 5'd0);

        // STAGES=3 depth: 00000 -> 00001.
        g3 = 5'b00001;
        tick();
        tick();
        chk("d3.e2.sync_grey", 16'(sg3), 16'd0);
        tick();
        chk("d3.e3.sync_grey", 16'(sg3), 16'd1);
        chk("d3.e3.sync_bin", 16'(sb3), 16'd0);
        chk("d3.e3.ptr_changed", 16'(pc3), 16'd0);
        tick();
        chk("d3.e4.sync_bin", 16'(sb3), 16'd1);
        chk("d3.e4.ptr_changed", 16'(pc3), 16'd1);
`ifdef GRAY_SYNC_DELTA_EN
        chk("d3.e4.ptr_delta", 16'(pd3), 16'd1);
`endif
        tick();
        chk("d3.e5.ptr_changed", 16'(pc3), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
